// File: rtl/ascii_frame_collector_pkg.sv
// Shared definitions for the ASCII frame collector: framing characters,
// FSM state encoding and the hex-character classifier.
package ascii_frame_collector_pkg;

  localparam int unsigned CHAR_W = 8;
  localparam int unsigned NCHARS = 4;
  localparam int unsigned IDX_W  = 2;

  localparam logic [CHAR_W-1:0] START_CHAR_DEF = 8'h3A;
  localparam logic [CHAR_W-1:0] TERM_CHAR_DEF  = 8'h0D;
  localparam logic [CHAR_W-1:0] RESET_CHAR     = 8'h30;

`ifdef ASCII_FRAME_TIMEOUT_EN
  localparam int unsigned TIMEOUT_CYC_DEF = 1000000;
`endif

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_COLLECT   = 2'd1;
  localparam logic [1:0] ST_WAIT_TERM = 2'd2;

  // Uppercase-only hex digits, matching the downstream decoder.
  function automatic logic is_hex_char(input logic [CHAR_W-1:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
  endfunction

endpackage

// File: rtl/ascii_frame_collector.sv
// Frames ':' + 4 hex chars + CR from the UART byte stream and publishes the
// hex chars atomically. Optional inter-character timeout: ASCII_FRAME_TIMEOUT_EN.
module ascii_frame_collector
  import ascii_frame_collector_pkg::*;
#(
  parameter logic [7:0] START_CHAR = START_CHAR_DEF,
  parameter logic [7:0] TERM_CHAR  = TERM_CHAR_DEF
`ifdef ASCII_FRAME_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic       rst,
  input  logic       clk,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] pd0,
  output logic [7:0] pd1,
  output logic [7:0] pd2,
  output logic [7:0] pd3,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       busy
);

  logic [1:0]                          state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [NCHARS-1:0][CHAR_W-1:0]       shadow_q, shadow_d;
  logic [NCHARS-1:0][CHAR_W-1:0]       pd_q, pd_d;
  logic                                frame_valid_q, frame_valid_d;
  logic                                frame_err_q, frame_err_d;
  logic                                busy_q, busy_d;
  logic                                rx_hex_c;

`ifdef ASCII_FRAME_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign rx_hex_c = is_hex_char(rx_data);

  // Next-state, shadow capture and pulse generation.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    pd_d          = pd_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == START_CHAR)) begin
          state_d = ST_COLLECT;
          idx_d   = '0;
        end
      end
      ST_COLLECT: begin
        if (rx_valid) begin
          if (rx_hex_c) begin
            shadow_d[idx_q] = rx_data;
            idx_d           = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NCHARS - 1)) begin
              state_d = ST_WAIT_TERM;
            end
          end else if (rx_data == START_CHAR) begin
            idx_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      ST_WAIT_TERM: begin
        if (rx_valid) begin
          if (rx_data == TERM_CHAR) begin
            pd_d          = shadow_q;
            frame_valid_d = 1'b1;
            state_d       = ST_IDLE;
          end else if (rx_data == START_CHAR) begin
            frame_err_d = 1'b1;
            state_d     = ST_COLLECT;
            idx_d       = '0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

`ifdef ASCII_FRAME_TIMEOUT_EN
    // A byte arriving on the expiry cycle wins over the timeout.
    cnt_d = cnt_q;
    if ((state_q == ST_IDLE) || rx_valid) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
      cnt_d       = '0;
      frame_err_d = 1'b1;
      state_d     = ST_IDLE;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      shadow_q      <= {NCHARS{RESET_CHAR}};
      pd_q          <= {NCHARS{RESET_CHAR}};
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      pd_q          <= pd_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
    end
  end

`ifdef ASCII_FRAME_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  assign pd0         = pd_q[0];
  assign pd1         = pd_q[1];
  assign pd2         = pd_q[2];
  assign pd3         = pd_q[3];
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;

endmodule
